// File: rtl/network_interface_if.sv
// Processor/router-facing bundle for one network interface node.
// Latency: n/a (signal grouping only).
// Backpressure: TX toward router is valid/ready (noc_ready); RX from router has none.
interface network_interface_if;
    // Processor TX side
    logic       tx_start;
    logic [1:0] tx_dest;
    logic [2:0] tx_len;
    logic [5:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_busy;
    // Router NI input
    logic [7:0] flit_out;
    logic       flit_out_valid;
    logic       noc_ready;
    // Router NI output
    logic [7:0] rx_flit;
    logic       rx_flit_valid;
    // Processor RX side
    logic [5:0] rx_data;
    logic       rx_data_valid;
    logic       rx_pkt_done;
    logic       rx_err;

    // Environment side: processor plus router
    modport master (
        output tx_start, tx_dest, tx_len, tx_data, tx_data_valid, noc_ready,
               rx_flit, rx_flit_valid,
        input  tx_data_ready, tx_busy, flit_out, flit_out_valid,
               rx_data, rx_data_valid, rx_pkt_done, rx_err
    );

    // Network interface block itself
    modport slave (
        input  tx_start, tx_dest, tx_len, tx_data, tx_data_valid, noc_ready,
               rx_flit, rx_flit_valid,
        output tx_data_ready, tx_busy, flit_out, flit_out_valid,
               rx_data, rx_data_valid, rx_pkt_done, rx_err
    );
endinterface

// File: rtl/network_interface.sv
// Packetizes 6-bit payload words into head/body/tail flits and depacketizes received flits.
// Latency: head flit one cycle after tx_start; RX outputs one cycle after the flit.
// Backpressure: flit_out held stable while noc_ready low, which also drops tx_data_ready; RX never stalls.
module network_interface #(
    parameter logic [1:0] NODE_ID = 2'd0
) (
    input  logic               clk,
    input  logic               rst,
    network_interface_if.slave ni
);

    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic [1:0] {TX_IDLE, TX_BODY, TX_TAIL} tx_state_t;
    typedef enum logic       {RX_WAIT_HEAD, RX_RECV}     rx_state_t;

    // ---------------- TX path ----------------
    tx_state_t  tx_state_q, tx_state_d;
    logic [2:0] tx_len_q,   tx_len_d;
    logic [2:0] tx_cnt_q,   tx_cnt_d;
    logic [5:0] tx_chk_q,   tx_chk_d;
    logic [7:0] flit_q,     flit_d;
    logic       flit_vld_q, flit_vld_d;
    logic       can_load;
    logic       tx_busy;
    logic       tx_rdy;

    // The output register may take a new flit when empty or draining this cycle
    assign can_load = !flit_vld_q || ni.noc_ready;
    assign tx_busy  = (tx_state_q != TX_IDLE) || flit_vld_q;

    // TX next state: an unloaded output register drains to zero/invalid
    always_comb begin
        tx_state_d = tx_state_q;
        tx_len_d   = tx_len_q;
        tx_cnt_d   = tx_cnt_q;
        tx_chk_d   = tx_chk_q;
        flit_d     = flit_q;
        flit_vld_d = flit_vld_q;
        tx_rdy     = 1'b0;
        if (can_load) begin
            flit_d     = '0;
            flit_vld_d = 1'b0;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (ni.tx_start && can_load && !tx_busy) begin
                    tx_len_d   = ni.tx_len;
                    tx_cnt_d   = '0;
                    tx_chk_d   = '0;
                    flit_d     = {FT_HEAD, ni.tx_dest, ni.tx_len, 1'b0};
                    flit_vld_d = 1'b1;
                    tx_state_d = (ni.tx_len != 3'd0) ? TX_BODY : TX_TAIL;
                end
            end
            TX_BODY: begin
                tx_rdy = can_load;
                if (ni.tx_data_valid && can_load) begin
                    flit_d     = {FT_BODY, ni.tx_data};
                    flit_vld_d = 1'b1;
                    tx_chk_d   = tx_chk_q ^ ni.tx_data;
                    tx_cnt_d   = tx_cnt_q + 3'd1;
                    if (tx_cnt_q + 3'd1 == tx_len_q) begin
                        tx_state_d = TX_TAIL;
                    end
                end
            end
            TX_TAIL: begin
                if (can_load) begin
                    flit_d     = {FT_TAIL, tx_chk_q};
                    flit_vld_d = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX state register; reset abandons any packet in flight without a tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_len_q   <= '0;
            tx_cnt_q   <= '0;
            tx_chk_q   <= '0;
            flit_q     <= '0;
            flit_vld_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_len_q   <= tx_len_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_chk_q   <= tx_chk_d;
            flit_q     <= flit_d;
            flit_vld_q <= flit_vld_d;
        end
    end

    assign ni.flit_out       = flit_q;
    assign ni.flit_out_valid = flit_vld_q;
    assign ni.tx_busy        = tx_busy;
    assign ni.tx_data_ready  = tx_rdy;

    // ---------------- RX path ----------------
    rx_state_t  rx_state_q, rx_state_d;
    logic [2:0] rx_len_q,   rx_len_d;
    logic [2:0] rx_cnt_q,   rx_cnt_d;
    logic [5:0] rx_chk_q,   rx_chk_d;
    logic [5:0] rx_data_q,  rx_data_d;
    logic       rx_dv_q,    rx_dv_d;
    logic       rx_done_q,  rx_done_d;
    logic       rx_err_q,   rx_err_d;
    logic [1:0] rx_type;
    logic [5:0] rx_pay;
    logic [1:0] rx_hdest;
    logic [2:0] rx_hlen;

    assign rx_type  = ni.rx_flit[7:6];
    assign rx_pay   = ni.rx_flit[5:0];
    assign rx_hdest = ni.rx_flit[5:4];
    assign rx_hlen  = ni.rx_flit[3:1];

    // RX next state: pulses default low, rx_data holds; a head mid-packet flags and restarts
    always_comb begin
        rx_state_d = rx_state_q;
        rx_len_d   = rx_len_q;
        rx_cnt_d   = rx_cnt_q;
        rx_chk_d   = rx_chk_q;
        rx_data_d  = rx_data_q;
        rx_dv_d    = 1'b0;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        if (ni.rx_flit_valid && rx_type != FT_IDLE) begin
            case (rx_state_q)
                RX_WAIT_HEAD: begin
                    if (rx_type == FT_HEAD && rx_hdest == NODE_ID) begin
                        rx_len_d   = rx_hlen;
                        rx_cnt_d   = '0;
                        rx_chk_d   = '0;
                        rx_state_d = RX_RECV;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
                RX_RECV: begin
                    case (rx_type)
                        FT_BODY: begin
                            if (rx_cnt_q < rx_len_q) begin
                                rx_data_d = rx_pay;
                                rx_dv_d   = 1'b1;
                                rx_chk_d  = rx_chk_q ^ rx_pay;
                                rx_cnt_d  = rx_cnt_q + 3'd1;
                            end else begin
                                rx_err_d   = 1'b1;
                                rx_state_d = RX_WAIT_HEAD;
                            end
                        end
                        FT_TAIL: begin
                            if (rx_cnt_q == rx_len_q && rx_pay == rx_chk_q) begin
                                rx_done_d = 1'b1;
                            end else begin
                                rx_err_d = 1'b1;
                            end
                            rx_state_d = RX_WAIT_HEAD;
                        end
                        default: begin
                            rx_err_d = 1'b1;
                            if (rx_hdest == NODE_ID) begin
                                rx_len_d   = rx_hlen;
                                rx_cnt_d   = '0;
                                rx_chk_d   = '0;
                                rx_state_d = RX_RECV;
                            end else begin
                                rx_state_d = RX_WAIT_HEAD;
                            end
                        end
                    endcase
                end
                default: rx_state_d = RX_WAIT_HEAD;
            endcase
        end
    end

    // RX state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_WAIT_HEAD;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_chk_q   <= '0;
            rx_data_q  <= '0;
            rx_dv_q    <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_chk_q   <= rx_chk_d;
            rx_data_q  <= rx_data_d;
            rx_dv_q    <= rx_dv_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign ni.rx_data       = rx_data_q;
    assign ni.rx_data_valid = rx_dv_q;
    assign ni.rx_pkt_done   = rx_done_q;
    assign ni.rx_err        = rx_err_q;

endmodule

// File: tb/tb_network_interface.sv
// Self-checking bench for network_interface: directed TX/RX packets plus randomized traffic.
// Latency: checks head one cycle after tx_start and RX outputs one cycle after each flit.
// Backpressure: randomly stalls noc_ready and checks flit hold and tx_data_ready drop.
`timescale 1ns/1ps
module tb_network_interface;

    localparam logic [1:0] NODE = 2'd0;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    network_interface_if ifc ();

    network_interface #(.NODE_ID(NODE)) dut (
        .clk (clk),
        .rst (rst),
        .ni  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- TX reference model and driver ----------------
    logic [7:0] tx_exp [$];
    logic [5:0] tx_pl [8];
    logic       prev_stall;
    logic [7:0] prev_flit;
    logic       idle_chk;
    int         first_pop;
    int         last_pop;

    // Expected flit stream of one packet, straight from the flit format
    task automatic push_model(input logic [1:0] dest, input int len);
        logic [5:0] x;
        x = '0;
        tx_exp.push_back({2'b01, dest, 3'(len), 1'b0});
        for (int i = 0; i < len; i++) begin
            tx_exp.push_back({2'b10, tx_pl[i]});
            x ^= tx_pl[i];
        end
        tx_exp.push_back({2'b11, x});
    endtask

    // One TX cycle: sample at negedge, drive inputs, score the transfer at the next posedge
    task automatic tx_cycle(input logic rdy, input int start_mode, input logic dvld,
                            input logic [5:0] dat, output logic acc);
        logic [7:0] e;
        logic       st;
        @(negedge clk);
        cyc++;
        if (idle_chk) begin
            check("busy_after_tail", ifc.tx_busy, 0);
            idle_chk = 1'b0;
        end
        if (prev_stall) begin
            check("flit_hold", ifc.flit_out, prev_flit);
            check("vld_hold", ifc.flit_out_valid, 1);
        end
        if (!ifc.flit_out_valid) check("flit_idle_zero", ifc.flit_out, 0);
        st = (start_mode == 1) || (start_mode == 2 && ifc.tx_busy && $urandom_range(3) == 0);
        if (start_mode == 2 && st) begin
            ifc.tx_dest = 2'($urandom_range(3));
            ifc.tx_len  = 3'($urandom_range(7));
        end
        ifc.tx_start      = st;
        ifc.noc_ready     = rdy;
        ifc.tx_data_valid = dvld;
        ifc.tx_data       = dat;
        #1;
        acc = dvld && ifc.tx_data_ready;
        if (ifc.flit_out_valid && !rdy) check("rdy_while_stalled", ifc.tx_data_ready, 0);
        if (ifc.flit_out_valid && rdy) begin
            if (tx_exp.size() == 0) begin
                check("tx_extra_flit", ifc.flit_out_valid, 0);
            end else begin
                e = tx_exp.pop_front();
                check("tx_flit", ifc.flit_out, e);
                if (e[7:6] == 2'b01) first_pop = cyc;
                if (e[7:6] == 2'b11) idle_chk = (tx_exp.size() == 0);
                last_pop = cyc;
            end
        end
        prev_stall = ifc.flit_out_valid && !rdy;
        prev_flit  = ifc.flit_out;
    endtask

    // Send one packet; payloads from tx_pl; expected flits from the model or pushed by caller
    task automatic send_pkt(input logic [1:0] dest, input int len, input int stall_pct,
                            input int gap_pct, input bit exact, input bit use_model);
        int   idx;
        int   n;
        int   sc;
        logic acc;
        logic rdy;
        logic dv;
        bit   done;
        if (use_model) begin
            for (int i = 0; i < 8; i++) tx_pl[i] = 6'($urandom_range(63));
            push_model(dest, len);
        end
        n = 0;
        while (ifc.tx_busy && n < 50) begin
            tx_cycle(1'b1, 0, 1'b0, 6'd0, acc);
            n++;
        end
        ifc.tx_dest = dest;
        ifc.tx_len  = 3'(len);
        tx_cycle(1'b1, 1, 1'b0, 6'd0, acc);
        sc   = cyc;
        idx  = 0;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            rdy = ($urandom_range(99) >= stall_pct);
            dv  = (idx < len) ? ($urandom_range(99) >= gap_pct) : 1'b1;
            tx_cycle(rdy, 2, dv, (idx < len) ? tx_pl[idx] : 6'($urandom_range(63)), acc);
            if (acc) begin
                if (idx >= len) check("tx_data_overaccept", acc, 0);
                else idx++;
            end
            n++;
            done = (idx == len) && (tx_exp.size() == 0) && !ifc.tx_busy;
        end
        check("tx_pkt_complete", done, 1);
        if (exact) begin
            check("head_latency", first_pop - sc, 1);
            check("pkt_span", last_pop - first_pop, len + 1);
        end
    endtask

    // ---------------- RX driver and expectations ----------------
    logic       p_dv;
    logic       p_done;
    logic       p_err;
    logic [5:0] p_data;
    logic       rx_open;

    // Check outputs due from the previous flit, then present a new one
    task automatic rx_step(input logic vld, input logic [7:0] f, input logic e_dv,
                           input logic [5:0] e_data, input logic e_done, input logic e_err);
        @(negedge clk);
        check("rx_data_valid", ifc.rx_data_valid, p_dv);
        check("rx_pkt_done", ifc.rx_pkt_done, p_done);
        check("rx_err", ifc.rx_err, p_err);
        check("rx_data", ifc.rx_data, p_data);
        ifc.rx_flit       = f;
        ifc.rx_flit_valid = vld;
        p_dv   = e_dv;
        p_done = e_done;
        p_err  = e_err;
        if (e_dv) p_data = e_data;
    endtask

    task automatic rx_gap();
        repeat ($urandom_range(1)) begin
            if ($urandom_range(1) == 1) rx_step(1'b1, {2'b00, 6'($urandom_range(63))}, 0, 0, 0, 0);
            else rx_step(1'b0, 8'($urandom), 0, 0, 0, 0);
        end
    endtask

    // kind: 0 good, 1 bad checksum, 2 extra body, 3 missing body, 4 foreign dest, 5 no tail
    task automatic rx_pkt(input int kind);
        int         len;
        int         nb;
        logic [1:0] dest;
        logic [5:0] pl;
        logic [5:0] x;
        logic [5:0] t;
        logic       good;
        len  = (kind == 3) ? int'($urandom_range(7, 1)) : int'($urandom_range(7));
        dest = (kind == 4) ? 2'($urandom_range(3, 1)) : NODE;
        nb   = (kind == 2) ? len + 1 : (kind == 3) ? len - 1 : len;
        rx_gap();
        rx_step(1'b1, {2'b01, dest, 3'(len), 1'b0}, 0, 0, 0, rx_open || (dest != NODE));
        rx_open = (dest == NODE);
        x = '0;
        for (int i = 0; i < nb; i++) begin
            pl = 6'($urandom_range(63));
            rx_gap();
            if (rx_open && i < len) begin
                rx_step(1'b1, {2'b10, pl}, 1, pl, 0, 0);
                x ^= pl;
            end else begin
                rx_step(1'b1, {2'b10, pl}, 0, 0, 0, 1);
                rx_open = 1'b0;
            end
        end
        if (kind != 5) begin
            t    = (kind == 1) ? (x ^ 6'($urandom_range(63, 1))) : x;
            good = rx_open && (nb == len) && (t == x);
            rx_gap();
            rx_step(1'b1, {2'b11, t}, 0, 0, good, !good);
            rx_open = 1'b0;
        end
    endtask

    // ---------------- Directed and random sequence ----------------
    initial begin
        logic acc;
        checks = 0; errors = 0; cyc = 0;
        prev_stall = 1'b0; prev_flit = '0; idle_chk = 1'b0;
        first_pop = 0; last_pop = 0;
        p_dv = 1'b0; p_done = 1'b0; p_err = 1'b0; p_data = '0; rx_open = 1'b0;
        rst = 1'b0;
        ifc.tx_start = 1'b0; ifc.tx_dest = '0; ifc.tx_len = '0;
        ifc.tx_data = '0; ifc.tx_data_valid = 1'b0; ifc.noc_ready = 1'b0;
        ifc.rx_flit = '0; ifc.rx_flit_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flit_out", ifc.flit_out, 0);
        check("rst_flit_valid", ifc.flit_out_valid, 0);
        check("rst_tx_busy", ifc.tx_busy, 0);
        check("rst_tx_ready", ifc.tx_data_ready, 0);
        check("rst_rx_data", ifc.rx_data, 0);
        check("rst_rx_valid", ifc.rx_data_valid, 0);
        check("rst_rx_done", ifc.rx_pkt_done, 0);
        check("rst_rx_err", ifc.rx_err, 0);
        rst = 1'b1;

        // Full-rate packet dest=2 len=3
        tx_pl[0] = 6'h15; tx_pl[1] = 6'h2A; tx_pl[2] = 6'h3F;
        tx_exp = '{8'h66, 8'h95, 8'hAA, 8'hBF, 8'hC0};
        send_pkt(2'd2, 3, 0, 0, 1'b1, 1'b0);

        // Empty packet dest=1: head then zero-checksum tail, no payload accepted
        tx_exp = '{8'h50, 8'hC0};
        send_pkt(2'd1, 0, 0, 0, 1'b1, 1'b0);

        // Stall for three cycles while 0xAA is pending; tx_start mid-packet is ignored
        tx_exp = '{8'h66, 8'h95, 8'hAA, 8'hBF, 8'hC0};
        ifc.tx_dest = 2'd2; ifc.tx_len = 3'd3;
        tx_cycle(1'b1, 1, 1'b0, 6'h00, acc);
        tx_cycle(1'b1, 0, 1'b1, 6'h15, acc); check("stall_acc0", acc, 1);
        tx_cycle(1'b1, 0, 1'b1, 6'h2A, acc); check("stall_acc1", acc, 1);
        ifc.tx_dest = 2'd1; ifc.tx_len = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tx_cycle(1'b0, 1, 1'b1, 6'h3F, acc);
            check("stall_no_accept", acc, 0);
        end
        tx_cycle(1'b1, 0, 1'b1, 6'h3F, acc); check("stall_acc2", acc, 1);
        repeat (6) tx_cycle(1'b1, 0, 1'b0, 6'h00, acc);
        check("stall_drained", tx_exp.size(), 0);

        // RX directed: good packet, bad checksum, foreign dest, orphan body, empty packet
        rx_step(1'b1, 8'h44, 0, 6'h00, 0, 0);
        rx_step(1'b1, 8'h81, 1, 6'h01, 0, 0);
        rx_step(1'b1, 8'h82, 1, 6'h02, 0, 0);
        rx_step(1'b1, 8'hC3, 0, 6'h00, 1, 0);
        rx_step(1'b1, 8'h44, 0, 6'h00, 0, 0);
        rx_step(1'b1, 8'h81, 1, 6'h01, 0, 0);
        rx_step(1'b1, 8'h82, 1, 6'h02, 0, 0);
        rx_step(1'b1, 8'hC4, 0, 6'h00, 0, 1);
        rx_step(1'b1, 8'h64, 0, 6'h00, 0, 1);
        rx_step(1'b1, 8'h81, 0, 6'h00, 0, 1);
        rx_step(1'b1, 8'h40, 0, 6'h00, 0, 0);
        rx_step(1'b1, 8'hC0, 0, 6'h00, 1, 0);
        rx_step(1'b0, 8'h00, 0, 6'h00, 0, 0);

        // RX random packet stream including malformed ones
        for (int p = 0; p < 24; p++) rx_pkt(int'($urandom_range(5)));
        rx_step(1'b0, 8'h00, 0, 6'h00, 0, 0);
        rx_step(1'b0, 8'h00, 0, 6'h00, 0, 0);

        // TX random packets with random stalls and payload gaps
        for (int p = 0; p < 12; p++)
            send_pkt(2'($urandom_range(3)), int'($urandom_range(7)), 30, 30, 1'b0, 1'b1);

        // Reset mid-packet after the second body flit has transferred
        tx_exp = '{8'h66, 8'h95, 8'hAA, 8'hBF, 8'hC0};
        ifc.tx_dest = 2'd2; ifc.tx_len = 3'd3;
        tx_cycle(1'b1, 1, 1'b0, 6'h00, acc);
        tx_cycle(1'b1, 0, 1'b1, 6'h15, acc);
        tx_cycle(1'b1, 0, 1'b1, 6'h2A, acc);
        tx_cycle(1'b1, 0, 1'b1, 6'h3F, acc);
        @(negedge clk);
        ifc.tx_data_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_flit_valid", ifc.flit_out_valid, 0);
        check("midrst_tx_busy", ifc.tx_busy, 0);
        check("midrst_flit_out", ifc.flit_out, 0);
        @(negedge clk);
        rst = 1'b1;
        tx_exp.delete();
        prev_stall = 1'b0; idle_chk = 1'b0;
        p_dv = 1'b0; p_done = 1'b0; p_err = 1'b0; p_data = '0;
        send_pkt(2'($urandom_range(3)), int'($urandom_range(7, 1)), 0, 0, 1'b1, 1'b1);
        repeat (3) tx_cycle(1'b1, 0, 1'b0, 6'h00, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
